// File: rtl/alu_share_arbiter_pkg.sv
// Shared constants for the ALU-sharing arbiter: operation codes, port ids,
// and the output-stage state encoding.
package alu_share_arbiter_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;
  localparam logic [2:0] ALU_SRL  = 3'b100;
  localparam logic [2:0] ALU_SLL  = 3'b101;
  localparam logic [2:0] ALU_SRA  = 3'b110;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [2:0] CMP_EQ  = 3'b000;
  localparam logic [2:0] CMP_SLT = 3'b001;
  localparam logic [2:0] CMP_SGT = 3'b010;
  localparam logic [2:0] CMP_ULT = 3'b011;
  localparam logic [2:0] CMP_UGT = 3'b100;
  localparam logic [2:0] CMP_NE  = 3'b101;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/alu_share_arbiter_alu.sv
// Combinational 32-bit ALU plus comparator; shifts act on operand B.
module alu_share_arbiter_alu
  import alu_share_arbiter_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [4:0]  i_shamt,
  input  logic [2:0]  i_aluop,
  input  logic [2:0]  i_cmpop,
  output logic [31:0] o_result,
  output logic        o_cmp
);

  // ALU datapath, 32-bit wraparound
  always_comb begin
    o_result = '0;
    case (i_aluop)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_SRL: o_result = i_b >> i_shamt;
      ALU_SLL: o_result = i_b << i_shamt;
      ALU_SRA: o_result = 32'($signed(i_b) >>> i_shamt);
      default: o_result = '0;
    endcase
  end

  // Comparator; unused codes yield 0
  always_comb begin
    o_cmp = 1'b0;
    case (i_cmpop)
      CMP_EQ:  o_cmp = (i_a == i_b);
      CMP_SLT: o_cmp = ($signed(i_a) < $signed(i_b));
      CMP_SGT: o_cmp = ($signed(i_a) > $signed(i_b));
      CMP_ULT: o_cmp = (i_a < i_b);
      CMP_UGT: o_cmp = (i_a > i_b);
      CMP_NE:  o_cmp = (i_a != i_b);
      default: o_cmp = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-port round-robin arbiter in front of one shared ALU. The winner's result
// is registered and returned on its response channel the cycle after accept.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [31:0]      opa_0,
  input  logic [31:0]      opb_0,
  input  logic [4:0]       shamt_0,
  input  logic [2:0]       aluop_0,
  input  logic [2:0]       cmpop_0,
  input  logic [31:0]      opa_1,
  input  logic [31:0]      opb_1,
  input  logic [4:0]       shamt_1,
  input  logic [2:0]       aluop_1,
  input  logic [2:0]       cmpop_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [31:0]      rsp_result,
  output logic             rsp_cmp,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
);

  out_state_e        r_state, w_state_nxt;
  logic              r_owner;
  logic              r_rr_ptr;
  logic [31:0]       r_result;
  logic              r_cmp;
  logic [CNT_W-1:0]  r_cnt_0, r_cnt_1;

  logic              w_drain, w_can_grant;
  logic              w_grant_0, w_grant_1;
  logic              w_xfer;
  logic [31:0]       w_a, w_b, w_alu_res;
  logic [4:0]        w_shamt;
  logic [2:0]        w_aluop, w_cmpop;
  logic              w_alu_cmp;

  // Slot frees when empty or when the owner drains this same cycle; gating
  // with reset keeps req_ready low while reset is asserted.
  assign w_drain     = (r_state == OUT_FULL) &
                       ((r_owner == PORT1) ? rsp_ready_1 : rsp_ready_0);
  assign w_can_grant = ~reset & ((r_state == OUT_EMPTY) | w_drain);

  // Lone requester wins; on contention rr_ptr names the winner
  assign w_grant_0   = req_valid_0 & (~req_valid_1 | (r_rr_ptr == PORT0));
  assign w_grant_1   = req_valid_1 & (~req_valid_0 | (r_rr_ptr == PORT1));
  assign req_ready_0 = w_can_grant & w_grant_0;
  assign req_ready_1 = w_can_grant & w_grant_1;
  assign w_xfer      = req_ready_0 | req_ready_1;

  // Operand mux keyed on the port-1 grant (port 0 otherwise)
  assign w_a     = w_grant_1 ? opa_1   : opa_0;
  assign w_b     = w_grant_1 ? opb_1   : opb_0;
  assign w_shamt = w_grant_1 ? shamt_1 : shamt_0;
  assign w_aluop = w_grant_1 ? aluop_1 : aluop_0;
  assign w_cmpop = w_grant_1 ? cmpop_1 : cmpop_0;

  alu_share_arbiter_alu u_alu (
    .i_a      (w_a),
    .i_b      (w_b),
    .i_shamt  (w_shamt),
    .i_aluop  (w_aluop),
    .i_cmpop  (w_cmpop),
    .o_result (w_alu_res),
    .o_cmp    (w_alu_cmp)
  );

  // Output-stage occupancy register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= OUT_EMPTY;
    else       r_state <= w_state_nxt;
  end

  // New transfer fills the slot; a drain alone empties it
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer)       w_state_nxt = OUT_FULL;
    else if (w_drain) w_state_nxt = OUT_EMPTY;
  end

  // Response valids follow occupancy and owner
  always_comb begin
    rsp_valid_0 = (r_state == OUT_FULL) & (r_owner == PORT0);
    rsp_valid_1 = (r_state == OUT_FULL) & (r_owner == PORT1);
  end

  // Result capture, owner and round-robin pointer update on transfer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner  <= PORT0;
      r_rr_ptr <= PORT0;
      r_result <= '0;
      r_cmp    <= 1'b0;
    end else if (w_xfer) begin
      r_owner  <= req_ready_1;
      r_rr_ptr <= ~req_ready_1;
      r_result <= w_alu_res;
      r_cmp    <= w_alu_cmp;
    end
  end

  // Saturating per-port grant counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt_0 <= '0;
      r_cnt_1 <= '0;
    end else begin
      if (req_ready_0 && (r_cnt_0 != {CNT_W{1'b1}})) r_cnt_0 <= r_cnt_0 + CNT_W'(1);
      if (req_ready_1 && (r_cnt_1 != {CNT_W{1'b1}})) r_cnt_1 <= r_cnt_1 + CNT_W'(1);
    end
  end

  assign rsp_result  = r_result;
  assign rsp_cmp     = r_cmp;
  assign grant_cnt_0 = r_cnt_0;
  assign grant_cnt_1 = r_cnt_1;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomized + directed bench for alu_share_arbiter against a behavioural model.
module tb_alu_share_arbiter;

  localparam int CNT_W = 2;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
  logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic [4:0]  s0 = 0, s1 = 0;
  logic [2:0]  ao0 = 0, co0 = 0, ao1 = 0, co1 = 0;
  logic        req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_cmp;
  logic [31:0] rsp_result;
  logic [CNT_W-1:0] grant_cnt_0, grant_cnt_1;

  int n_chk = 0, n_err = 0;

  // model state
  bit          m_full, m_owner, m_ptr, m_cmp;
  logic [31:0] m_res;
  int          m_c0, m_c1;
  int          grants[$];
  bit          last_g0, last_g1;

  always #5 clk = ~clk;

  alu_share_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(v0), .req_valid_1(v1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .opa_0(a0), .opb_0(b0), .shamt_0(s0), .aluop_0(ao0), .cmpop_0(co0),
    .opa_1(a1), .opb_1(b1), .shamt_1(s1), .aluop_1(ao1), .cmpop_1(co1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rr0), .rsp_ready_1(rr1),
    .rsp_result(rsp_result), .rsp_cmp(rsp_cmp),
    .grant_cnt_0(grant_cnt_0), .grant_cnt_1(grant_cnt_1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [31:0] a, b, input logic [4:0] s,
                                          input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a | b;
      3'd3: return a & b;
      3'd4: return b >> s;
      3'd5: return b << s;
      3'd6: return (b >> s) | (b[31] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit ref_cmp(input logic [31:0] a, b, input logic [2:0] op);
    int signed sa, sb;
    sa = a; sb = b;
    case (op)
      3'd0: return a == b;
      3'd1: return sa < sb;
      3'd2: return sa > sb;
      3'd3: return a < b;
      3'd4: return a > b;
      3'd5: return a != b;
      default: return 1'b0;
    endcase
  endfunction

  task automatic mreset();
    m_full = 0; m_owner = 0; m_ptr = 0; m_cmp = 0; m_res = 0; m_c0 = 0; m_c1 = 0;
  endtask

  // Called just after a negedge with inputs set: checks outputs, advances the
  // model across the next posedge, and returns at the following negedge.
  task automatic step();
    bit drain, can, g0, g1;
    #1;
    drain = m_full && (m_owner ? rr1 : rr0);
    can   = !m_full || drain;
    g0 = can && v0 && (!v1 || !m_ptr);
    g1 = can && v1 && (!v0 || m_ptr);
    chk("req_ready_0", {31'b0, req_ready_0}, {31'b0, g0});
    chk("req_ready_1", {31'b0, req_ready_1}, {31'b0, g1});
    chk("rsp_valid_0", {31'b0, rsp_valid_0}, {31'b0, m_full && !m_owner});
    chk("rsp_valid_1", {31'b0, rsp_valid_1}, {31'b0, m_full && m_owner});
    if (m_full) begin
      chk("rsp_result", rsp_result, m_res);
      chk("rsp_cmp", {31'b0, rsp_cmp}, {31'b0, m_cmp});
    end
    chk("grant_cnt_0", 32'(grant_cnt_0), m_c0);
    chk("grant_cnt_1", 32'(grant_cnt_1), m_c1);
    last_g0 = g0; last_g1 = g1;
    if (g0) begin
      m_res = ref_alu(a0, b0, s0, ao0); m_cmp = ref_cmp(a0, b0, co0);
      m_full = 1; m_owner = 0; m_ptr = 1; if (m_c0 < CMAX) m_c0++;
      grants.push_back(0);
    end else if (g1) begin
      m_res = ref_alu(a1, b1, s1, ao1); m_cmp = ref_cmp(a1, b1, co1);
      m_full = 1; m_owner = 1; m_ptr = 0; if (m_c1 < CMAX) m_c1++;
      grants.push_back(1);
    end else if (drain) m_full = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; v0 = 0; v1 = 0;
    repeat (2) @(negedge clk);
    reset = 0; mreset(); grants.delete();
  endtask

  task automatic rnd_port0();
    v0 = ($urandom % 4) != 0; a0 = $urandom; b0 = ($urandom % 4 == 0) ? a0 : $urandom;
    s0 = 5'($urandom); ao0 = 3'($urandom); co0 = 3'($urandom);
  endtask

  task automatic rnd_port1();
    v1 = ($urandom % 4) != 0; a1 = $urandom; b1 = ($urandom % 4 == 0) ? a1 : $urandom;
    s1 = 5'($urandom); ao1 = 3'($urandom); co1 = 3'($urandom);
  endtask

  initial begin
    mreset();
    @(negedge clk);
    #1;
    chk("reset_req_ready_0", {31'b0, req_ready_0}, 32'd0);
    chk("reset_rsp_valid_0", {31'b0, rsp_valid_0}, 32'd0);
    do_reset();

    // Port 0 add
    v0 = 1; a0 = 5; b0 = 7; ao0 = 3'b000; co0 = 3'b000; rr0 = 1; rr1 = 1;
    step();
    v0 = 0;
    #1;
    chk("t1_valid0", {31'b0, rsp_valid_0}, 32'd1);
    chk("t1_result", rsp_result, 32'd12);
    chk("t1_cmp", {31'b0, rsp_cmp}, 32'd0);
    chk("t1_valid1", {31'b0, rsp_valid_1}, 32'd0);
    step();

    // Contention round-robin
    do_reset();
    v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
    for (int i = 0; i < 4; i++) begin
      a0 = i; b0 = 10; a1 = i; b1 = 20;
      step();
    end
    v0 = 0; v1 = 0;
    chk("rr_order0", grants[0], 0);
    chk("rr_order1", grants[1], 1);
    chk("rr_order2", grants[2], 0);
    chk("rr_order3", grants[3], 1);
    #1;
    chk("rr_cnt0", 32'(grant_cnt_0), 32'd2);
    chk("rr_cnt1", 32'(grant_cnt_1), 32'd2);
    step();

    // Backpressure on port 0 blocks port 1
    do_reset();
    v0 = 1; a0 = 5; b0 = 7; ao0 = 0; rr0 = 0; rr1 = 1;
    step();
    v0 = 0; v1 = 1; a1 = 3; b1 = 4; ao1 = 3'b001; co1 = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ready1", {31'b0, req_ready_1}, 32'd0);
      chk("bp_result", rsp_result, 32'd12);
      step();
    end
    rr0 = 1;
    #1;
    chk("bp_release_ready1", {31'b0, req_ready_1}, 32'd1);
    step();
    v1 = 0;
    #1;
    chk("bp_valid1", {31'b0, rsp_valid_1}, 32'd1);
    step();

    // Port 1 sra and compares, back-to-back
    v1 = 1; a1 = 0; b1 = 32'h8000_0000; s1 = 4; ao1 = 3'b110; co1 = 0;
    step();
    a1 = 32'hFFFF_FFFF; b1 = 1; ao1 = 0; co1 = 3'b001;
    #1;
    chk("sra_result", rsp_result, 32'hF800_0000);
    step();
    co1 = 3'b011;
    #1;
    chk("slt_cmp", {31'b0, rsp_cmp}, 32'd1);
    step();
    v1 = 0;
    #1;
    chk("ult_cmp", {31'b0, rsp_cmp}, 32'd0);
    step();

    // Saturation then async reset with pending result
    do_reset();
    v0 = 1; rr0 = 1; a0 = 1; b0 = 1; ao0 = 0;
    repeat (6) step();
    #1;
    chk("sat_cnt0", 32'(grant_cnt_0), 32'd3);
    step();
    v0 = 0; rr0 = 0; v1 = 1;
    #2 reset = 1;
    #1;
    chk("async_valid0", {31'b0, rsp_valid_0}, 32'd0);
    chk("async_ready1", {31'b0, req_ready_1}, 32'd0);
    chk("async_cnt0", 32'(grant_cnt_0), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 0; mreset(); v0 = 1; v1 = 1; rr0 = 1; rr1 = 1;
    #1;
    chk("post_rst_valid0", {31'b0, rsp_valid_0}, 32'd0);
    chk("post_rst_ptr0", {31'b0, req_ready_0}, 32'd1);
    step();
    v0 = 0; v1 = 0;
    step();

    // Randomized traffic with the requester contract honoured
    do_reset();
    rnd_port0(); rnd_port1();
    for (int i = 0; i < 3000; i++) begin
      rr0 = ($urandom % 4) != 0;
      rr1 = ($urandom % 4) != 0;
      step();
      if (!v0 || last_g0) rnd_port0();
      if (!v1 || last_g1) rnd_port1();
      if ((i % 500) == 499) do_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
